tape_step_controller: RTL and testbench
=======================================

Name: tape_step_controller

Overview:
- Sequences each head step between the tape storage and utm_core_PROJECT_ID:
  - owns the tape cell array and the head pointer;
  - presents the symbol under the head to the core and waits for the core's reply;
  - writes the reply back and moves the head.
- Also provides host tape loading, run/halt control, a step budget, and fault detection for edge and timeout.

Parameters:
- DEPTH, 32, number of tape cells (power of two, ≥4).
- SYM_W, 3, symbol width in bits.
- BLANK_SYM, 0, value written to every cell on reset.
- START_POS, 16, head position after reset and on each start.
- MAX_STEPS, 1000, completed steps after which the run stops (done).
- WAIT_TIMEOUT, 15, maximum WAIT cycles before a timeout fault.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  host write of one tape cell; honoured only in IDLE.
- load_addr  in  log2(DEPTH)  cell index for load.
- load_data  in  SYM_W  symbol for load.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- halt_req  in  1  level; stop after the current step completes.
- sym  out  SYM_W  symbol under the head, presented to the core.
- sym_valid  out  1  one-cycle strobe: sym is valid.
- new_sym  in  SYM_W  core's symbol to write.
- direction  in  1  core's move: 1 = right (+1), 0 = left (−1).
- step_valid  in  1  core reply strobe: new_sym and direction are valid.
- running  out  1  high while not IDLE.
- done  out  1  sticky; the run ended by step budget or halt_req.
- fault  out  2  sticky: 0 none, 1 left edge, 2 right edge, 3 timeout.
- head_pos  out  log2(DEPTH)  current head index.
- step_count  out  16  completed steps this run.

Behaviour:
- Reset (synchronous, takes effect from any state):
  - FSM goes to IDLE; head_pos = START_POS; step_count = 0.
  - sym = 0, sym_valid = 0, running = 0, done = 0, fault = 0.
  - All cells are set to BLANK_SYM.
- States: IDLE, FETCH, PRESENT, WAIT, WRITE.
- IDLE:
  - load_en writes cell[load_addr] at the clock edge.
  - start moves the FSM to FETCH, sets head_pos = START_POS, clears step_count, done and fault.
  - If start and load_en occur in the same cycle: the load is applied and start is honoured.
- FETCH: sym <= cell[head_pos]; go to PRESENT.
- PRESENT:
  - sym_valid = 1 for exactly this cycle; sym is held stable until the next FETCH.
  - Go to WAIT.
- WAIT:
  - step_valid is sampled only here; it is ignored in all other states.
  - On step_valid: latch new_sym and direction, go to WRITE.
  - Wait counter: reset on entry to WAIT. If WAIT_TIMEOUT cycles pass without step_valid: fault = 3, go to IDLE.
- WRITE:
  - Write cell[head_pos] <= new_sym (always, including when an edge fault follows).
  - step_count increments.
  - Edge handling:
    - If direction = 0 and head_pos = 0: fault = 1, head unchanged, go to IDLE.
    - If direction = 1 and head_pos = DEPTH−1: fault = 2, head unchanged, go to IDLE.
    - Otherwise the head moves ±1.
  - Exit order:
    - If the incremented step_count equals MAX_STEPS, or halt_req is high: done = 1, go to IDLE.
    - Otherwise go to FETCH.
  - A fault takes precedence over done; both are never set together.
- Latency:
  - start in cycle t gives sym_valid in cycle t+2.
  - step_valid in cycle w gives the cell write and head move at the end of cycle w+1, and the next sym_valid in cycle w+3.
- Ignored inputs: start while running; load_en while running.
- halt_req never aborts mid-step; asserting it in IDLE has no effect.
- running = (state != IDLE), as a registered output.

Test Plan:
- Reset, then start with a core model that replies new_sym = 5, direction = 1, step_valid two cycles after each sym_valid, and halt_req raised in step 3 → cells 16, 17, 18 = 5; head_pos = 19; step_count = 3; done = 1; fault = 0.
- Load cell 16 = 3 in IDLE, then start → first sym_valid 2 cycles after start with sym = 3; a load_en pulse while running leaves the tape unchanged.
- Load the head to position 0 via START_POS = 0 (instantiated in the bench), core replies direction = 0 → cell 0 written, fault = 1, head_pos = 0, running = 0.
- Core never asserts step_valid → fault = 3 exactly WAIT_TIMEOUT cycles after the WAIT entry; no cell is written.
- MAX_STEPS = 4, core always moves right → done = 1 after step 4; step_count = 4; head_pos = 20; a new start clears done and step_count.
- Synchronous reset asserted during WAIT → next cycle: IDLE, all cells BLANK_SYM, head_pos = START_POS, all status outputs 0.

Source files
------------

// File: rtl/tape_step_controller_if.sv
// Core-side step handshake: symbol out to the core, reply back.
// master = tape controller, slave = core.
interface tape_step_controller_if #(
  parameter int SYM_W = 3
);
  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic [SYM_W-1:0] new_sym;
  logic             direction;
  logic             step_valid;

  modport master (
    output sym, sym_valid,
    input  new_sym, direction, step_valid
  );

  modport slave (
    input  sym, sym_valid,
    output new_sym, direction, step_valid
  );
endinterface

// File: rtl/tape_step_controller.sv
// Tape storage, head pointer and step sequencer for the TM core.
// Ports: clock/reset, host load, start/halt_req, core if, status.
module tape_step_controller #(
  parameter int DEPTH        = 32,
  parameter int SYM_W        = 3,
  parameter int BLANK_SYM    = 0,
  parameter int START_POS    = 16,
  parameter int MAX_STEPS    = 1000,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [SYM_W-1:0]         load_data,
  input  logic                     start,
  input  logic                     halt_req,
  tape_step_controller_if.master   core,
  output logic                     running,
  output logic                     done,
  output logic [1:0]               fault,
  output logic [$clog2(DEPTH)-1:0] head_pos,
  output logic [15:0]              step_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int WT_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [AW-1:0]    POS0  = AW'(START_POS);
  localparam logic [AW-1:0]    LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    ONE   = AW'(1);
  localparam logic [SYM_W-1:0] BLANK = SYM_W'(BLANK_SYM);
  localparam logic [15:0]      MAX_C = 16'(MAX_STEPS);
  localparam logic [WT_W-1:0]  WT_LAST = WT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, PRESENT, WAIT, WRITE
  } state_t;

  state_t state_q, state_d;

  logic [SYM_W-1:0] cells [DEPTH];
  logic [SYM_W-1:0] new_sym_q;
  logic             dir_q;
  logic [WT_W-1:0]  wcnt_q;

  logic        edge_l, edge_r, edge_hit;
  logic        timeout_hit, finish;
  logic [15:0] step_inc;
  logic        sym_valid_d, running_d;

  assign step_inc    = step_count + 16'd1;
  assign edge_l      = !dir_q && (head_pos == '0);
  assign edge_r      = dir_q && (head_pos == LAST);
  assign edge_hit    = edge_l || edge_r;
  assign finish      = (step_inc == MAX_C) || halt_req;
  assign timeout_hit = !core.step_valid && (wcnt_q == WT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = PRESENT;
      PRESENT: state_d = WAIT;
      WAIT: begin
        if (core.step_valid) state_d = WRITE;
        else if (timeout_hit) state_d = IDLE;
      end
      WRITE: begin
        if (edge_hit || finish) state_d = IDLE;
        else state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with it.
  always_comb begin
    sym_valid_d = (state_d == PRESENT);
    running_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      head_pos       <= POS0;
      step_count     <= '0;
      core.sym       <= '0;
      core.sym_valid <= 1'b0;
      running        <= 1'b0;
      done           <= 1'b0;
      fault          <= 2'd0;
      wcnt_q         <= '0;
      new_sym_q      <= '0;
      dir_q          <= 1'b0;
      for (int i = 0; i < DEPTH; i++) cells[i] <= BLANK;
    end else begin
      state_q        <= state_d;
      core.sym_valid <= sym_valid_d;
      running        <= running_d;
      unique case (state_q)
        IDLE: begin
          if (load_en) cells[load_addr] <= load_data;
          if (start) begin
            head_pos   <= POS0;
            step_count <= '0;
            done       <= 1'b0;
            fault      <= 2'd0;
          end
        end
        FETCH:   core.sym <= cells[head_pos];
        PRESENT: wcnt_q <= '0;
        WAIT: begin
          wcnt_q <= wcnt_q + WT_W'(1);
          if (core.step_valid) begin
            new_sym_q <= core.new_sym;
            dir_q     <= core.direction;
          end else if (timeout_hit) begin
            fault <= 2'd3;
          end
        end
        WRITE: begin
          cells[head_pos] <= new_sym_q;
          step_count      <= step_inc;
          // Edge fault leaves the head put and suppresses done.
          unique case (1'b1)
            edge_l: fault <= 2'd1;
            edge_r: fault <= 2'd2;
            default: begin
              head_pos <= dir_q ? head_pos + ONE
                                : head_pos - ONE;
              if (finish) done <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tape_step_controller.sv
// Directed and randomized checks of tape_step_controller.
// Two instances share stimulus; each test observes one of them.
module tb_tape_step_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic [4:0] load_addr = '0;
  logic [2:0] load_data = '0;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic [2:0] new_sym = '0;
  logic       direction = 1'b0;
  logic       step_valid = 1'b0;

  logic        run_a, done_a, run_b, done_b;
  logic [1:0]  fault_a, fault_b;
  logic [4:0]  head_a;
  logic [2:0]  head_b;
  logic [15:0] cnt_a, cnt_b;

  tape_step_controller_if #(.SYM_W(3)) ca ();
  tape_step_controller_if #(.SYM_W(3)) cb ();

  assign ca.new_sym    = new_sym;
  assign ca.direction  = direction;
  assign ca.step_valid = step_valid;
  assign cb.new_sym    = new_sym;
  assign cb.direction  = direction;
  assign cb.step_valid = step_valid;

  tape_step_controller #(.MAX_STEPS(4)) dut_a (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start),
    .halt_req(halt_req), .core(ca),
    .running(run_a), .done(done_a), .fault(fault_a),
    .head_pos(head_a), .step_count(cnt_a)
  );

  tape_step_controller #(
    .DEPTH(8), .START_POS(0), .MAX_STEPS(20)
  ) dut_b (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr[2:0]),
    .load_data(load_data), .start(start),
    .halt_req(halt_req), .core(cb),
    .running(run_b), .done(done_b), .fault(fault_b),
    .head_pos(head_b), .step_count(cnt_b)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_sv(bit sel, int exp, string tag);
    int n = 0;
    while (!(sel ? cb.sym_valid : ca.sym_valid) && n < 40) begin
      tick(1);
      n++;
    end
    chk(tag, n, exp);
  endtask

  task automatic wait_idle(bit sel);
    int n = 0;
    while ((sel ? run_b : run_a) && n < 40) begin
      tick(1);
      n++;
    end
    chk("idle", sel ? run_b : run_a, 0);
  endtask

  // From the sym_valid cycle: reply d cycles later, hold halt
  // through the write cycle, return two cycles after the reply.
  task automatic do_step(logic [2:0] ns, bit dr, int d, bit h);
    tick(d);
    new_sym = ns;
    direction = dr;
    step_valid = 1'b1;
    halt_req = h;
    tick(1);
    step_valid = 1'b0;
    tick(1);
    halt_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  int m [8];
  int hd, st, fexp, dexp, nb, d;
  bit ended, dr, h;
  logic [2:0] ns;

  initial begin
    do_reset();
    chk("rst_run", run_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_fault", fault_a, 0);
    chk("rst_head", head_a, 16);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_sym", ca.sym, 0);
    chk("rst_sv", ca.sym_valid, 0);

    // Three right moves writing 5, halt in step 3.
    pulse_start();
    wait_sv(0, 1, "lat_start");
    for (int k = 1; k <= 3; k++) begin
      do_step(3'd5, 1'b1, 2, k == 3);
      if (k < 3) wait_sv(0, 1, "lat_step");
    end
    wait_idle(0);
    chk("h_c16", dut_a.cells[16], 5);
    chk("h_c17", dut_a.cells[17], 5);
    chk("h_c18", dut_a.cells[18], 5);
    chk("h_head", head_a, 19);
    chk("h_cnt", cnt_a, 3);
    chk("h_done", done_a, 1);
    chk("h_fault", fault_a, 0);

    // Load in IDLE, then timeout with ignored loads/start.
    load_en = 1'b1; load_addr = 5'd16; load_data = 3'd3;
    tick(1);
    load_en = 1'b0;
    pulse_start();
    wait_sv(0, 1, "lat_load");
    chk("ld_sym", ca.sym, 3);
    load_en = 1'b1; load_data = 3'd7;
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    chk("to_pre_fault", fault_a, 0);
    chk("to_pre_run", run_a, 1);
    load_en = 1'b0;
    tick(1);
    chk("to_fault", fault_a, 3);
    chk("to_run", run_a, 0);
    chk("to_c16", dut_a.cells[16], 3);
    chk("to_c17", dut_a.cells[17], 5);
    chk("to_cnt", cnt_a, 0);

    // Step budget of 4, always right.
    do_reset();
    pulse_start();
    wait_sv(0, 1, "lat_b0");
    for (int k = 0; k < 4; k++) begin
      do_step(3'(k + 1), 1'b1, 1, 1'b0);
      if (k < 3) wait_sv(0, 1, "lat_b");
    end
    wait_idle(0);
    chk("b_done", done_a, 1);
    chk("b_cnt", cnt_a, 4);
    chk("b_head", head_a, 20);
    chk("b_fault", fault_a, 0);
    chk("b_c19", dut_a.cells[19], 4);
    pulse_start();
    chk("b2_done", done_a, 0);
    chk("b2_cnt", cnt_a, 0);
    chk("b2_run", run_a, 1);

    // Reset while waiting for the core.
    wait_sv(0, 1, "lat_r");
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 32; i++) nb += (dut_a.cells[i] != 3'd0) ? 1 : 0;
    chk("r_blank", nb, 0);
    chk("r_run", run_a, 0);
    chk("r_head", head_a, 16);
    chk("r_cnt", cnt_a, 0);
    chk("r_done", done_a, 0);
    chk("r_fault", fault_a, 0);
    chk("r_sym", ca.sym, 0);
    chk("r_sv", ca.sym_valid, 0);

    // Left edge from position 0 on the small tape.
    pulse_start();
    wait_sv(1, 1, "lat_e");
    chk("e_sym", cb.sym, 0);
    do_step(3'd6, 1'b0, 1, 1'b0);
    wait_idle(1);
    chk("e_c0", dut_b.cells[0], 6);
    chk("e_fault", fault_b, 1);
    chk("e_head", head_b, 0);
    chk("e_done", done_b, 0);
    chk("e_cnt", cnt_b, 1);

    // Randomized runs against a step-level tape model.
    for (int i = 0; i < 8; i++) m[i] = 0;
    m[0] = 6;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < $urandom_range(0, 2); k++) begin
        load_en = 1'b1;
        load_addr = 5'($urandom_range(0, 7));
        load_data = 3'($urandom);
        m[load_addr[2:0]] = load_data;
        tick(1);
      end
      load_en = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        load_en = 1'b1;
        load_addr = 5'($urandom_range(0, 7));
        load_data = 3'($urandom);
        m[load_addr[2:0]] = load_data;
      end
      pulse_start();
      load_en = 1'b0;
      hd = 0; st = 0; fexp = 0; dexp = 0; ended = 1'b0;
      while (!ended) begin
        wait_sv(1, 1, "rn_lat");
        chk("rn_sym", cb.sym, m[hd]);
        if ($urandom_range(0, 19) == 0) begin
          tick(16);
          chk("rn_to_fault", fault_b, 3);
          fexp = 3;
          ended = 1'b1;
        end else begin
          ns = 3'($urandom);
          dr = 1'($urandom_range(0, 1));
          d = $urandom_range(1, 15);
          h = ($urandom_range(0, 9) == 0);
          do_step(ns, dr, d, h);
          m[hd] = ns;
          st++;
          if (!dr && hd == 0) begin
            fexp = 1; ended = 1'b1;
          end else if (dr && hd == 7) begin
            fexp = 2; ended = 1'b1;
          end else begin
            hd = dr ? hd + 1 : hd - 1;
            if (st == 20 || h) begin
              dexp = 1; ended = 1'b1;
            end
          end
        end
      end
      wait_idle(1);
      chk("rn_fault", fault_b, fexp);
      chk("rn_done", done_b, dexp);
      chk("rn_head", head_b, hd);
      chk("rn_cnt", cnt_b, st);
      for (int i = 0; i < 8; i++) chk("rn_tape", dut_b.cells[i], m[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
